// File: rtl/btn_conditioner.sv
// Button/switch front end: two-flop synchronizers on all raw inputs, plus a
// per-button debounce FSM producing a clean level and a one-cycle press strobe.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] btn_raw,
  input  logic [7:0] sw_raw,
  output logic [1:0] btn_level,
  output logic [1:0] btn_pulse,
  output logic [7:0] sw_sync
);

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CHK = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0] btn_m_q, btn_s_q;
  logic [7:0] sw_m_q, sw_s_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_m_q <= '0;
      btn_s_q <= '0;
      sw_m_q  <= '0;
      sw_s_q  <= '0;
    end else begin
      btn_m_q <= btn_raw;
      btn_s_q <= btn_m_q;
      sw_m_q  <= sw_raw;
      sw_s_q  <= sw_m_q;
    end
  end

  assign sw_sync = sw_s_q;

  for (genvar i = 0; i < 2; i++) begin : g_btn
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
      case (state_q)
        RELEASED: begin
          if (btn_s_q[i]) begin
            state_d = PRESS_CHK;
            cnt_d   = '0;
          end
        end
        PRESS_CHK: begin
          if (!btn_s_q[i]) begin
            state_d = RELEASED;
          end else if (cnt_q == CNT_LAST) begin
            state_d = HELD;
            pulse_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        HELD: begin
          if (!btn_s_q[i]) begin
            state_d = RELEASE_CHK;
            cnt_d   = '0;
          end
        end
        RELEASE_CHK: begin
          if (btn_s_q[i]) begin
            state_d = HELD;
          end else if (cnt_q == CNT_LAST) begin
            state_d = RELEASED;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = RELEASED;
      endcase
      // Outputs are registered from the next state so they line up with the FSM.
      level_d = (state_d == HELD) || (state_d == RELEASE_CHK);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= RELEASED;
        cnt_q   <= '0;
        level_q <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        level_q <= level_d;
        pulse_q <= pulse_d;
      end
    end

    assign btn_level[i] = level_q;
    assign btn_pulse[i] = pulse_q;
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner with a short debounce window: fixed vector table,
// hand-built corner sequences, then random stimulus against a run-length model.
module tb_btn_conditioner;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] btn_raw;
  logic [7:0] sw_raw;
  logic [1:0] btn_level;
  logic [1:0] btn_pulse;
  logic [7:0] sw_sync;

  int checks   = 0;
  int failures = 0;

  btn_conditioner #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .sw_raw   (sw_raw),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse),
    .sw_sync  (sw_sync)
  );

  always #5 clk = ~clk;

  // Reference: inputs reach the debouncer two edges late; a button's level
  // flips once DEB+1 consecutive samples disagree with it, and the press
  // strobe marks a flip to 1.
  logic [1:0] bdly [2];
  logic [7:0] sdly [2];
  int         run_m [2];
  logic [1:0] lvl_m, pls_m;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bdly[0] <= '0; bdly[1] <= '0;
      sdly[0] <= '0; sdly[1] <= '0;
      run_m[0] <= 0; run_m[1] <= 0;
      lvl_m <= '0;
      pls_m <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (bdly[1][i] != lvl_m[i]) begin
          if (run_m[i] == DEB) begin
            lvl_m[i] <= bdly[1][i];
            pls_m[i] <= bdly[1][i];
            run_m[i] <= 0;
          end else begin
            run_m[i] <= run_m[i] + 1;
            pls_m[i] <= 1'b0;
          end
        end else begin
          run_m[i] <= 0;
          pls_m[i] <= 1'b0;
        end
      end
      bdly[0] <= btn_raw;
      bdly[1] <= bdly[0];
      sdly[0] <= sw_raw;
      sdly[1] <= sdly[0];
    end
  end

  typedef struct {
    logic [1:0] btn;
    logic [7:0] sw;
    logic [1:0] lvl;
    logic [1:0] pls;
    logic [7:0] sw_exp;
  } vec_t;

  vec_t tbl [21];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Clean press of bit0, short release glitch, then a full release.
    tbl[0]  = '{2'b01, 8'hA5, 2'b00, 2'b00, 8'h00};
    tbl[1]  = '{2'b01, 8'h3C, 2'b00, 2'b00, 8'hA5};
    tbl[2]  = '{2'b01, 8'h3C, 2'b00, 2'b00, 8'h3C};
    tbl[3]  = '{2'b01, 8'h3C, 2'b00, 2'b00, 8'h3C};
    tbl[4]  = '{2'b01, 8'h3C, 2'b00, 2'b00, 8'h3C};
    tbl[5]  = '{2'b01, 8'h3C, 2'b00, 2'b00, 8'h3C};
    tbl[6]  = '{2'b01, 8'h3C, 2'b01, 2'b01, 8'h3C};
    tbl[7]  = '{2'b01, 8'h3C, 2'b01, 2'b00, 8'h3C};
    tbl[8]  = '{2'b00, 8'h3C, 2'b01, 2'b00, 8'h3C};
    tbl[9]  = '{2'b00, 8'h3C, 2'b01, 2'b00, 8'h3C};
    tbl[10] = '{2'b01, 8'h3C, 2'b01, 2'b00, 8'h3C};
    tbl[11] = '{2'b01, 8'h3C, 2'b01, 2'b00, 8'h3C};
    tbl[12] = '{2'b01, 8'h3C, 2'b01, 2'b00, 8'h3C};
    for (int r = 13; r < 19; r++) tbl[r] = '{2'b00, 8'h3C, 2'b01, 2'b00, 8'h3C};
    tbl[19] = '{2'b00, 8'h3C, 2'b00, 2'b00, 8'h3C};
    tbl[20] = '{2'b00, 8'h3C, 2'b00, 2'b00, 8'h3C};

    rst = 1'b1;
    btn_raw = '0;
    sw_raw = 8'hFF;
    repeat (2) tick();
    check("reset_level", {6'd0, btn_level}, 8'h00);
    check("reset_pulse", {6'd0, btn_pulse}, 8'h00);
    check("reset_sw", sw_sync, 8'h00);
    sw_raw = 8'h00;
    rst = 1'b0;
    repeat (3) tick();

    for (int r = 0; r < 21; r++) begin
      btn_raw = tbl[r].btn;
      sw_raw  = tbl[r].sw;
      tick();
      check($sformatf("tbl%0d_level", r), {6'd0, btn_level}, {6'd0, tbl[r].lvl});
      check($sformatf("tbl%0d_pulse", r), {6'd0, btn_pulse}, {6'd0, tbl[r].pls});
      check($sformatf("tbl%0d_sw", r), sw_sync, tbl[r].sw_exp);
    end

    // Clean press on bit1 held for 100 cycles: one strobe only.
    btn_raw = 2'b10;
    for (int c = 1; c <= 100; c++) begin
      tick();
      check($sformatf("press1_pulse_c%0d", c), {6'd0, btn_pulse}, (c == 7) ? 8'h02 : 8'h00);
      check($sformatf("press1_level_c%0d", c), {6'd0, btn_level}, (c >= 7) ? 8'h02 : 8'h00);
    end
    btn_raw = 2'b00;
    repeat (10) tick();
    check("press1_released", {6'd0, btn_level}, 8'h00);

    // Bounce on bit0: 1,0,1,0 then steady 1; strobe 7 edges after the last rise.
    for (int c = 1; c <= 20; c++) begin
      btn_raw = (c <= 4) ? {1'b0, c[0]} : 2'b01;
      tick();
      check($sformatf("bounce_pulse_c%0d", c), {6'd0, btn_pulse}, (c == 11) ? 8'h01 : 8'h00);
      check($sformatf("bounce_level_c%0d", c), {6'd0, btn_level}, (c >= 11) ? 8'h01 : 8'h00);
    end

    // Asynchronous clear of a held level and of the switch path.
    #2 rst = 1'b1;
    #1;
    check("async_rst_level", {6'd0, btn_level}, 8'h00);
    check("async_rst_sw", sw_sync, 8'h00);
    repeat (2) tick();
    btn_raw = 2'b00;
    rst = 1'b0;
    repeat (10) tick();
    check("sw_after_reset", sw_sync, 8'h3C);

    // Simultaneous press on both buttons.
    btn_raw = 2'b11;
    for (int c = 1; c <= 10; c++) begin
      tick();
      check($sformatf("simul_pulse_c%0d", c), {6'd0, btn_pulse}, (c == 7) ? 8'h03 : 8'h00);
    end
    btn_raw = 2'b00;
    repeat (10) tick();

    // Reset during the press check, button kept down through reset release.
    btn_raw = 2'b01;
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    check("midchk_rst_pulse", {6'd0, btn_pulse}, 8'h00);
    check("midchk_rst_level", {6'd0, btn_level}, 8'h00);
    tick();
    check("midchk_hold_pulse", {6'd0, btn_pulse}, 8'h00);
    tick();
    rst = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      check($sformatf("midchk_pulse_c%0d", c), {6'd0, btn_pulse}, (c == 7) ? 8'h01 : 8'h00);
    end
    btn_raw = 2'b00;
    repeat (10) tick();

    // Random stimulus with long-ish stable stretches, against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) btn_raw[$urandom_range(0, 1)] ^= 1'b1;
      sw_raw = 8'($urandom);
      rst = ($urandom_range(0, 399) == 0);
      tick();
      check("rand_level", {6'd0, btn_level}, {6'd0, lvl_m});
      check("rand_pulse", {6'd0, btn_pulse}, {6'd0, pls_m});
      check("rand_sw", sw_sync, sdly[1]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
